// File: rtl/rsa_operand_loader_if.sv
// Word-stream in, full operands out, for the RSA operand loader.
// The source side drives words and the ack; the loader drives the rest.
interface rsa_operand_loader_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 32
);
    localparam int OP_W  = WORD_W * NUM_WORDS;
    localparam int MSB_W = $clog2(OP_W);
    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    logic              startInput;
    logic              word_valid;
    logic [WORD_W-1:0] n_input;
    logic [WORD_W-1:0] m_input;
    logic [WORD_W-1:0] e_input;
    logic              load_ready;
    logic              op_valid;
    logic              op_ack;
    logic [OP_W-1:0]   n_op;
    logic [OP_W-1:0]   m_op;
    logic [OP_W-1:0]   e_op;
    logic [MSB_W-1:0]  e_msb;
    logic              e_zero;
    logic              m_ge_n;
    logic              n_even;
    logic [CNT_W-1:0]  word_cnt;

    modport master (
        output startInput, word_valid,
        output n_input, m_input, e_input,
        output op_ack,
        input  load_ready, op_valid,
        input  n_op, m_op, e_op,
        input  e_msb, e_zero, m_ge_n, n_even,
        input  word_cnt
    );

    modport slave (
        input  startInput, word_valid,
        input  n_input, m_input, e_input,
        input  op_ack,
        output load_ready, op_valid,
        output n_op, m_op, e_op,
        output e_msb, e_zero, m_ge_n, n_even,
        output word_cnt
    );
endinterface

// File: rtl/rsa_operand_loader.sv
// Assembles n/m/e word streams into full operands and tracks the
// exponent leading one, m >= n and n parity while loading.
module rsa_operand_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 32
) (
    input logic clk,
    input logic reset,
    rsa_operand_loader_if.slave bus
);
    localparam int OP_W  = WORD_W * NUM_WORDS;
    localparam int MSB_W = $clog2(OP_W);
    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } state_t;

    // EQ is encoded as zero so the reset value is a fresh tracker
    typedef enum logic [1:0] {
        CMP_EQ,
        CMP_LT,
        CMP_GT
    } cmp_t;

    state_t state_q, state_d;
    cmp_t   cmp_q, cmp_d;

    logic [OP_W-1:0]  n_q, m_q, e_q;
    logic [MSB_W-1:0] e_msb_q;
    logic [MSB_W-1:0] word_base;
    logic [CNT_W-1:0] word_cnt_q;
    logic             e_zero_q;
    logic             m_ge_n_q;
    logic             n_even_q;
    logic             clear;
    logic             capture;

    function automatic logic [MSB_W-1:0] lead_one(
        input logic [WORD_W-1:0] w
    );
        lead_one = '0;
        for (int i = 0; i < WORD_W; i++) begin
            if (w[i]) lead_one = MSB_W'(i);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.startInput) begin
                    state_d = LOAD;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                if (bus.startInput) begin
                    clear = 1'b1;
                end else if (bus.word_valid) begin
                    capture = 1'b1;
                    if (word_cnt_q == CNT_W'(NUM_WORDS - 1))
                        state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.op_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmp_d = cmp_q;
        if (cmp_q == CMP_EQ) begin
            if (bus.m_input > bus.n_input)
                cmp_d = CMP_GT;
            else if (bus.m_input < bus.n_input)
                cmp_d = CMP_LT;
        end
    end

    // Bit offset of the current word once the frame is complete
    assign word_base = MSB_W'(
        (NUM_WORDS - 1 - int'(word_cnt_q)) * WORD_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cmp_q      <= CMP_EQ;
            n_q        <= '0;
            m_q        <= '0;
            e_q        <= '0;
            e_msb_q    <= '0;
            word_cnt_q <= '0;
            e_zero_q   <= 1'b0;
            m_ge_n_q   <= 1'b0;
            n_even_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                cmp_q      <= CMP_EQ;
                n_q        <= '0;
                m_q        <= '0;
                e_q        <= '0;
                e_msb_q    <= '0;
                word_cnt_q <= '0;
                e_zero_q   <= 1'b1;
                m_ge_n_q   <= 1'b1;
                n_even_q   <= 1'b0;
            end else if (capture) begin
                n_q <= {n_q[OP_W-WORD_W-1:0], bus.n_input};
                m_q <= {m_q[OP_W-WORD_W-1:0], bus.m_input};
                e_q <= {e_q[OP_W-WORD_W-1:0], bus.e_input};
                word_cnt_q <= word_cnt_q + CNT_W'(1);
                cmp_q      <= cmp_d;
                m_ge_n_q   <= (cmp_d != CMP_LT);
                n_even_q   <= ~bus.n_input[0];
                // e_zero doubles as "no set bit seen yet"
                if (e_zero_q && (bus.e_input != '0)) begin
                    e_msb_q  <= word_base + lead_one(bus.e_input);
                    e_zero_q <= 1'b0;
                end
            end
        end
    end

    assign bus.load_ready = (state_q == LOAD);
    assign bus.op_valid   = (state_q == HOLD);
    assign bus.n_op       = n_q;
    assign bus.m_op       = m_q;
    assign bus.e_op       = e_q;
    assign bus.e_msb      = e_msb_q;
    assign bus.e_zero     = e_zero_q;
    assign bus.m_ge_n     = m_ge_n_q;
    assign bus.n_even     = n_even_q;
    assign bus.word_cnt   = word_cnt_q;
endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed bench for rsa_operand_loader: frames, gaps, abort,
// exponent corner cases and the HOLD handshake.
module tb_rsa_operand_loader;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rsa_operand_loader_if #(.WORD_W(32), .NUM_WORDS(32)) bus ();

    rsa_operand_loader #(.WORD_W(32), .NUM_WORDS(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0=n 1=m 2=e; v selects the data set
    function automatic logic [31:0] word(input int which,
                                         input int i,
                                         input int v);
        logic [31:0] n, m, e;
        n = (i == 0)  ? 32'h8B9496E5 :
            (i == 31) ? 32'hA938A368 :
            32'h13579BDF ^ (32'(i) * 32'h01010101);
        m = (i == 0) ? 32'h40C517E0 : 32'(i) * 32'h01234567;
        e = (i == 0) ? 32'h70A34C81 : 32'(i) * 32'h9E3779B9;
        case (v)
            1: e = (i < 3) ? 32'h0 : (i == 3) ? 32'h1 : e;
            2: e = 32'h0;
            3: m = n;
            4: begin n = '1; m = '1; e = '1; end
            default: ;
        endcase
        return (which == 0) ? n : (which == 1) ? m : e;
    endfunction

    function automatic logic [1023:0] exp_op(input int which,
                                             input int v);
        logic [1023:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            r[1023-32*i -: 32] = word(which, i, v);
        return r;
    endfunction

    task automatic put_word(input int i, input int v);
        bus.word_valid = 1'b1;
        bus.n_input    = word(0, i, v);
        bus.m_input    = word(1, i, v);
        bus.e_input    = word(2, i, v);
    endtask

    // Start a frame (with a junk word alongside start) and stream it.
    task automatic run_frame(input int v,
                             input logic [127:0] gaps,
                             output int first,
                             output logic [5:0] cnt0);
        int wi;
        int cyc;
        if (bus.op_valid) begin
            bus.op_ack = 1'b1;
            step();
            bus.op_ack = 1'b0;
        end
        bus.startInput = 1'b1;
        put_word(0, 4);
        step();
        cnt0 = bus.word_cnt;
        bus.startInput = 1'b0;
        wi = 0;
        cyc = 1;
        first = -1;
        while (cyc < 100 && first < 0) begin
            if (gaps[cyc] || wi >= 32) begin
                bus.word_valid = 1'b0;
            end else begin
                put_word(wi, v);
                wi++;
            end
            step();
            cyc++;
            if (bus.op_valid) first = cyc;
        end
        bus.word_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.startInput = 1'b1;
        step();
        bus.startInput = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put_word(i, 0);
            step();
        end
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        bus.word_valid = 1'b0;
        checks++;
        if ({bus.load_ready, bus.op_valid, bus.e_zero,
             bus.m_ge_n, bus.n_even} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.load_ready, bus.op_valid, bus.e_zero,
                      bus.m_ge_n, bus.n_even});
        end
        checks++;
        if (bus.word_cnt !== 6'd0 || bus.e_msb !== 10'd0) begin
            errors++;
            $display("FAIL reset_cnt: cnt=%0d msb=%0d expected 0/0",
                     bus.word_cnt, bus.e_msb);
        end
        checks++;
        if ({bus.n_op, bus.m_op, bus.e_op} !== 3072'b0) begin
            errors++;
            $display("FAIL reset_ops: n_hi=%h e_hi=%h expected 0",
                     bus.n_op[1023:960], bus.e_op[1023:960]);
        end
    endtask

    task automatic test_full_frame();
        int first;
        logic [5:0] c0;
        run_frame(0, '0, first, c0);
        checks++;
        if (first !== 33) begin
            errors++;
            $display("FAIL full_latency: got %0d expected 33", first);
        end
        checks++;
        if (bus.n_op[1023:992] !== 32'h8B9496E5) begin
            errors++;
            $display("FAIL full_n_top: got %h expected 8b9496e5",
                     bus.n_op[1023:992]);
        end
        checks++;
        if ({bus.n_op, bus.m_op, bus.e_op} !==
            {exp_op(0, 0), exp_op(1, 0), exp_op(2, 0)}) begin
            errors++;
            $display("FAIL full_ops: n_lo=%h expected %h",
                     bus.n_op[63:0], exp_op(0, 0) & 1024'hFFFFFFFFFFFFFFFF);
        end
        checks++;
        if ({bus.e_msb, bus.e_zero, bus.m_ge_n, bus.n_even} !==
            {10'd1022, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL full_flags: msb=%0d z=%b ge=%b ev=%b expected 1022 0 0 1",
                     bus.e_msb, bus.e_zero, bus.m_ge_n, bus.n_even);
        end
        checks++;
        if (bus.word_cnt !== 6'd32 || bus.load_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_cnt: cnt=%0d rdy=%b expected 32 0",
                     bus.word_cnt, bus.load_ready);
        end
    endtask

    task automatic test_gapped();
        int first;
        logic [5:0] c0;
        logic [127:0] gaps;
        gaps = '0;
        gaps[3] = 1'b1;
        gaps[9] = 1'b1;
        gaps[15] = 1'b1;
        gaps[22] = 1'b1;
        gaps[30] = 1'b1;
        run_frame(0, gaps, first, c0);
        checks++;
        if (first !== 38) begin
            errors++;
            $display("FAIL gap_latency: got %0d expected 38", first);
        end
        checks++;
        if ({bus.n_op, bus.m_op, bus.e_op} !==
            {exp_op(0, 0), exp_op(1, 0), exp_op(2, 0)} ||
            {bus.e_msb, bus.m_ge_n, bus.n_even} !==
            {10'd1022, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL gap_result: n_hi=%h msb=%0d expected %h 1022",
                     bus.n_op[1023:960], bus.e_msb,
                     exp_op(0, 0) >> 960);
        end
    endtask

    task automatic test_abort();
        int first;
        logic [5:0] c0;
        bus.op_ack = 1'b1;
        step();
        bus.op_ack = 1'b0;
        bus.startInput = 1'b1;
        step();
        bus.startInput = 1'b0;
        for (int i = 0; i < 10; i++) begin
            put_word(i, 4);
            step();
        end
        run_frame(0, '0, first, c0);
        checks++;
        if (c0 !== 6'd0) begin
            errors++;
            $display("FAIL abort_cnt: got %0d expected 0", c0);
        end
        checks++;
        if (first !== 33) begin
            errors++;
            $display("FAIL abort_latency: got %0d expected 33", first);
        end
        checks++;
        if ({bus.n_op, bus.m_op, bus.e_op} !==
            {exp_op(0, 0), exp_op(1, 0), exp_op(2, 0)} ||
            {bus.e_msb, bus.m_ge_n} !== {10'd1022, 1'b0}) begin
            errors++;
            $display("FAIL abort_result: e_hi=%h msb=%0d expected %h 1022",
                     bus.e_op[1023:960], bus.e_msb,
                     exp_op(2, 0) >> 960);
        end
    endtask

    task automatic test_exponent_edges();
        int first;
        logic [5:0] c0;
        run_frame(1, '0, first, c0);
        checks++;
        if ({bus.e_msb, bus.e_zero} !== {10'd896, 1'b0} ||
            bus.e_op !== exp_op(2, 1)) begin
            errors++;
            $display("FAIL e_word3: msb=%0d z=%b expected 896 0",
                     bus.e_msb, bus.e_zero);
        end
        run_frame(2, '0, first, c0);
        checks++;
        if ({bus.e_msb, bus.e_zero} !== {10'd0, 1'b1}) begin
            errors++;
            $display("FAIL e_zero: msb=%0d z=%b expected 0 1",
                     bus.e_msb, bus.e_zero);
        end
        run_frame(3, '0, first, c0);
        checks++;
        if ({bus.m_ge_n, bus.n_even, bus.e_msb} !==
            {1'b1, 1'b1, 10'd1022}) begin
            errors++;
            $display("FAIL m_eq_n: ge=%b ev=%b msb=%0d expected 1 1 1022",
                     bus.m_ge_n, bus.n_even, bus.e_msb);
        end
    endtask

    task automatic test_handshake();
        int first;
        logic [5:0] c0;
        run_frame(0, '0, first, c0);
        for (int i = 0; i < 5; i++) begin
            bus.startInput = i[0];
            put_word(i, 4);
            bus.word_valid = ~i[0];
            step();
            checks++;
            if (bus.op_valid !== 1'b1 || bus.word_cnt !== 6'd32 ||
                bus.n_op !== exp_op(0, 0) ||
                bus.e_msb !== 10'd1022) begin
                errors++;
                $display("FAIL hold_%0d: vld=%b cnt=%0d msb=%0d expected 1 32 1022",
                         i, bus.op_valid, bus.word_cnt, bus.e_msb);
            end
        end
        bus.startInput = 1'b0;
        bus.word_valid = 1'b0;
        bus.op_ack = 1'b1;
        step();
        bus.op_ack = 1'b0;
        checks++;
        if ({bus.op_valid, bus.load_ready} !== 2'b00 ||
            bus.n_op !== exp_op(0, 0)) begin
            errors++;
            $display("FAIL ack_idle: vld=%b rdy=%b expected 0 0, ops kept",
                     bus.op_valid, bus.load_ready);
        end
        bus.startInput = 1'b1;
        step();
        bus.startInput = 1'b0;
        checks++;
        if (bus.load_ready !== 1'b1 || bus.word_cnt !== 6'd0 ||
            bus.n_op !== '0) begin
            errors++;
            $display("FAIL restart: rdy=%b cnt=%0d expected 1 0",
                     bus.load_ready, bus.word_cnt);
        end
        bus.op_ack = 1'b1;
        step();
        bus.op_ack = 1'b0;
        checks++;
        if ({bus.load_ready, bus.op_valid} !== 2'b10) begin
            errors++;
            $display("FAIL ack_in_load: rdy=%b vld=%b expected 1 0",
                     bus.load_ready, bus.op_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.startInput = 1'b0;
        bus.word_valid = 1'b0;
        bus.op_ack = 1'b0;
        bus.n_input = '0;
        bus.m_input = '0;
        bus.e_input = '0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_full_frame();
        test_gapped();
        test_abort();
        test_exponent_edges();
        test_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
